vga_scanout: RTL
================

# vga_scanout

- Downstream consumer of the double-buffered framebuffer.
- Generates 640x480@60 VGA timing from the 50 MHz system clock and drives framebuffer read coordinates at 2x upscale (320x240 source).
- Converts the returned 3-bit colour into 4-bit-per-channel VGA outputs.
- Emits the `new_frame` pulse the framebuffer uses to swap buffers.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BACK`, 33, vertical back porch (lines)

Ports:
- `Clk` input 1: system clock, 50 MHz.
- `Reset` input 1: synchronous, active-high.
- `fb_coords` output screenXY: framebuffer read address.
- `fb_color` input 3: framebuffer colour {r,g,b}, valid 1 Clk after `fb_coords`.
- `new_frame` output 1: one-Clk pulse at start of vertical blanking.
- `pix_en` output 1: pixel-rate strobe, high every 2nd Clk (DAC/pixel clock source).
- `VGA_R`, `VGA_G`, `VGA_B` output 4 each: colour channels.
- `VGA_HS`, `VGA_VS` output 1 each: syncs, active-low.
- `VGA_BLANK` output 1: high while the output pixel is outside the visible area.

## Operation
- Phase toggle `ph` flips every Clk; `pix_en = ph`. All counters and outputs advance only when `pix_en` is high.
- `hc`, 10 bits, counts 0..799 and wraps to 0. On wrap, `vc`, 10 bits, increments over 0..524 and wraps to 0. Totals are parameter sums.
- Visible when `hc < H_VISIBLE && vc < V_VISIBLE`.
  - Visible: `fb_coords.x = hc>>1`, `fb_coords.y = vc>>1` (x 0..319, y 0..239).
  - Otherwise: `fb_coords` = (0,0).
  - Driven combinationally from the counters.
- Sync decode (raw, before pipeline):
  - HS low for `656 <= hc < 752`.
  - VS low for `490 <= vc < 492`.
- Output stage: on each `pix_en`, register the following together, so every output lags the counters by exactly one pixel period:
  - RGB = `fb_color` expansion when visible, else 0.
  - Raw HS, VS and blank.
- Colour expansion: each bit maps to 4'hF when set, 4'h0 when clear. R = bit 2, G = bit 1, B = bit 0.
- `new_frame` is high for exactly one Clk, on the Clk where `pix_en` is high and the counters move to `hc=0, vc=480`.
  - Exactly one pulse per frame.
  - Never asserted during the visible area.
- Reset mid-frame: counters, phase and outputs return to reset values on the next edge. No `new_frame` pulse is generated by the reset itself.

## Timing
- Reset values:
  - `hc=0`, `vc=0`, `ph=0`, `pix_en=0`.
  - `VGA_HS=1`, `VGA_VS=1`, `VGA_BLANK=1`, RGB=0, `new_frame=0`.
- Framebuffer read latency is 1 Clk. `fb_color` is sampled on the next `pix_en` edge, 2 Clk after the address.
- Pixel period 2 Clk. Line 1600 Clk. Frame 525 lines = 840000 Clk.
- HS low width 192 Clk. VS low width 3200 Clk.
- Each source pixel appears on 2 consecutive output pixels and 2 consecutive lines.
- Counter wrap, `new_frame` and output registration all occur on the same `pix_en` edge. No extra cycle is inserted at wrap.

## Configuration
- `SCANOUT_TESTPATTERN_EN`
  - Defined:
    - Adds input `test_mode` (1 bit).
    - While `test_mode` is high, `fb_color` is ignored and the visible colour index is `fb_coords.x[8:6]` (vertical bars 128 output pixels wide, indices 0..4).
    - Timing, syncs and `new_frame` are unchanged.
  - Undefined: port absent; colour always comes from `fb_color`.

## Test plan
- Reset:
  - Assert Reset 3 Clk mid-line.
  - Required: `VGA_HS=1`, `VGA_VS=1`, `VGA_BLANK=1`, RGB=0, `new_frame=0`.
  - First `pix_en` is on the 2nd Clk after release.
- Sync timing:
  - Run 2 frames.
  - HS low 192 Clk every 1600 Clk.
  - VS low 3200 Clk every 840000 Clk.
  - `VGA_BLANK` low for exactly 1280 Clk per visible line.
- `new_frame`:
  - Over 3 frames, exactly 3 single-Clk pulses, spaced 840000 Clk apart.
  - Each pulse coincides with the counters entering `vc=480`, `hc=0`.
- Upscale mapping:
  - Bench model returns `fb_color = (x+y)%8`, with 1-Clk latency.
  - Output pixels (2,0) and (3,0) both show colour 1 (B=4'hF, R=G=0).
  - Pixel (0,2) shows colour 1.
  - Pixel (639,479) shows colour (319+239)%8 = 6.
- Blanking:
  - Bench model drives `fb_color=7` constantly.
  - RGB=0 whenever `VGA_BLANK=1`, including `hc` 640..799 and `vc` 480..524.
- Test pattern (`SCANOUT_TESTPATTERN_EN` defined, `test_mode=1`, `fb_color=0`):
  - Output x=0 gives colour 0.
  - x=128 gives colour 1 (B only).
  - x=512 gives colour 4 (R only).

Source files
------------

// File: rtl/vga_scanout.sv
// vga_scanout
//   640x480@60 VGA scanout driven from the 50 MHz system clock. The pixel rate is
//   half the system clock (pix_en every second Clk). Reads the framebuffer at 2x
//   upscale (320x240 source). Expands the 3-bit colour to 4 bits per channel.
//   Emits new_frame, which the framebuffer uses to swap buffers.
//
// Ports
//   Clk        in   system clock (50 MHz)
//   Reset      in   synchronous, active-high
//   fb_coords  out  framebuffer read address {x[8:0], y[7:0]}, combinational
//   fb_color   in   framebuffer colour {r,g,b}, valid 1 Clk after fb_coords
//   new_frame  out  one-Clk pulse when the counters enter the first blanking line
//   pix_en     out  pixel-rate strobe, high every second Clk
//   VGA_R/G/B  out  4-bit colour channels, zero outside the visible area
//   VGA_HS/VS  out  active-low syncs
//   VGA_BLANK  out  high while the output pixel is outside the visible area
//
// Build option
//   SCANOUT_TESTPATTERN_EN  adds input test_mode. When test_mode is high, the
//                           colour index comes from source x[8:6], which gives
//                           vertical bars. fb_color is ignored in that case.

typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
} screenXY;

module vga_scanout #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    output screenXY    fb_coords,
    input  logic [2:0] fb_color,
`ifdef SCANOUT_TESTPATTERN_EN
    input  logic       test_mode,
`endif
    output logic       new_frame,
    output logic       pix_en,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK
);

    localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] HLast    = 10'(HTotal - 1);
    localparam logic [9:0] VLast    = 10'(VTotal - 1);
    localparam logic [9:0] HVis     = 10'(H_VISIBLE);
    localparam logic [9:0] VVis     = 10'(V_VISIBLE);
    localparam logic [9:0] HsStart  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HsEnd    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VsStart  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VsEnd    = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    // The last visible line. Leaving its last pixel starts vertical blanking.
    localparam logic [9:0] VVisLast = 10'(V_VISIBLE - 1);

    logic       ph_q;
    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       h_last, v_last;
    logic       visible;
    logic       hs_raw, vs_raw;
    logic       new_frame_d;
    logic [2:0] color_idx;

    assign pix_en = ph_q;

    // Counter next-state
    always_comb begin
        h_last = (hc_q == HLast);
        v_last = (vc_q == VLast);
        hc_d   = h_last ? 10'd0 : hc_q + 10'd1;
        vc_d   = vc_q;
        if (h_last) begin
            vc_d = v_last ? 10'd0 : vc_q + 10'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ph_q <= 1'b0;
            hc_q <= 10'd0;
            vc_q <= 10'd0;
        end else begin
            ph_q <= ~ph_q;
            if (ph_q) begin
                hc_q <= hc_d;
                vc_q <= vc_d;
            end
        end
    end

    // Raw decode from the live counters
    always_comb begin
        visible = (hc_q < HVis) && (vc_q < VVis);
        hs_raw  = ~((hc_q >= HsStart) && (hc_q < HsEnd));
        vs_raw  = ~((vc_q >= VsStart) && (vc_q < VsEnd));

        // 2x upscale: each source pixel covers 2 columns and 2 lines
        fb_coords.x = visible ? hc_q[9:1] : 9'd0;
        fb_coords.y = visible ? vc_q[8:1] : 8'd0;

        // This pulse is registered on the same pix_en edge that moves the
        // counters onto (0, V_VISIBLE).
        new_frame_d = ph_q && h_last && (vc_q == VVisLast);
    end

    // The colour index is sampled at the pix_en edge. The address was issued
    // 2 Clk earlier, which covers the 1-Clk framebuffer read latency.
    always_comb begin
`ifdef SCANOUT_TESTPATTERN_EN
        color_idx = test_mode ? fb_coords.x[8:6] : fb_color;
`else
        color_idx = fb_color;
`endif
    end

    // Output stage: every output lags the counters by one pixel period
    always_ff @(posedge Clk) begin
        if (Reset) begin
            VGA_R     <= 4'h0;
            VGA_G     <= 4'h0;
            VGA_B     <= 4'h0;
            VGA_HS    <= 1'b1;
            VGA_VS    <= 1'b1;
            VGA_BLANK <= 1'b1;
            new_frame <= 1'b0;
        end else begin
            new_frame <= new_frame_d;
            if (ph_q) begin
                VGA_R     <= (visible && color_idx[2]) ? 4'hF : 4'h0;
                VGA_G     <= (visible && color_idx[1]) ? 4'hF : 4'h0;
                VGA_B     <= (visible && color_idx[0]) ? 4'hF : 4'h0;
                VGA_HS    <= hs_raw;
                VGA_VS    <= vs_raw;
                VGA_BLANK <= ~visible;
            end
        end
    end

endmodule
